// File: rtl/jt5205_enc_if.sv
// Sample-in / code-out bus of the jt5205 ADPCM encoder.
// Handshake: a sample moves on a clk edge where cen=1, din_valid=1 and
// din_ready=1 (flush and restart low). The source holds din/din_valid
// until then. code_valid and dout_valid are single-clk pulses with no
// back-pressure.
interface jt5205_enc_if;
   logic [11:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        flush;
   logic [3:0]  code;
   logic        code_valid;
   logic [11:0] pred;
   logic [5:0]  idx;
   logic [7:0]  dout;
   logic        dout_valid;

   modport master (
      output din, din_valid, flush,
      input  din_ready, code, code_valid, pred, idx, dout, dout_valid
   );

   modport slave (
      input  din, din_valid, flush,
      output din_ready, code, code_valid, pred, idx, dout, dout_valid
   );
endinterface

// File: rtl/jt5205_enc.sv
// OKI/MSM5205-compatible 4-bit ADPCM encoder. One code bit is resolved
// per cen edge (B2, B1, B0), then the predictor and step index are updated
// exactly as a non-interpolating jt5205 decoder would. Codes are packed in
// pairs into bytes in PCM-ROM order.
module jt5205_enc #(
   parameter bit PACK_HI_FIRST = 1'b1,
   parameter int INIT_IDX      = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        restart,
   jt5205_enc_if.slave bus,
   output logic [2:0]  state_dbg
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_B2   = 3'd1;
   localparam logic [2:0] S_B1   = 3'd2;
   localparam logic [2:0] S_B0   = 3'd3;
   localparam logic [2:0] S_UPD  = 3'd4;
   localparam logic [5:0] IDX0   = 6'(INIT_IDX);

   function automatic logic [10:0] step_of(input logic [5:0] i);
      case (i)
         6'd0:  return 11'd16;   6'd1:  return 11'd17;   6'd2:  return 11'd19;
         6'd3:  return 11'd21;   6'd4:  return 11'd23;   6'd5:  return 11'd25;
         6'd6:  return 11'd28;   6'd7:  return 11'd31;   6'd8:  return 11'd34;
         6'd9:  return 11'd37;   6'd10: return 11'd41;   6'd11: return 11'd45;
         6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;
         6'd15: return 11'd66;   6'd16: return 11'd73;   6'd17: return 11'd80;
         6'd18: return 11'd88;   6'd19: return 11'd97;   6'd20: return 11'd107;
         6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
         6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;
         6'd27: return 11'd209;  6'd28: return 11'd230;  6'd29: return 11'd253;
         6'd30: return 11'd279;  6'd31: return 11'd307;  6'd32: return 11'd337;
         6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
         6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;
         6'd39: return 11'd658;  6'd40: return 11'd724;  6'd41: return 11'd796;
         6'd42: return 11'd876;  6'd43: return 11'd963;  6'd44: return 11'd1060;
         6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
         default: return 11'd1552;
      endcase
   endfunction

   // Places the earlier code in the slot the decoder reads first.
   function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
      return PACK_HI_FIRST ? {first, second} : {second, first};
   endfunction

   logic [2:0]  state_q, state_d;
   logic        sign_q, sign_d;
   logic [11:0] d_q, d_d;
   logic [10:0] st_q, st_d;
   logic [11:0] vp_q, vp_d;
   logic [2:0]  cb_q, cb_d;
   logic [11:0] pred_q, pred_d;
   logic [5:0]  idx_q, idx_d;
   logic [3:0]  code_q, code_d;
   logic        code_valid_q, code_valid_d;
   logic [7:0]  dout_q, dout_d;
   logic        dout_valid_q, dout_valid_d;
   logic        phase_q, phase_d;
   logic [3:0]  first_q, first_d;

   logic signed [12:0] diff;
   logic [11:0]        mag;
   logic [10:0]        st_sel;
   logic [11:0]        st_full, st_half, st_quarter;
   logic signed [13:0] pred_sum;
   logic signed [7:0]  adj;
   logic signed [7:0]  idx_sum;
   logic [3:0]         code_new;

   // Next-state logic: successive-approximation FSM, predictor update and packing.
   always_comb begin
      state_d      = state_q;
      sign_d       = sign_q;
      d_d          = d_q;
      st_d         = st_q;
      vp_d         = vp_q;
      cb_d         = cb_q;
      pred_d       = pred_q;
      idx_d        = idx_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      phase_d      = phase_q;
      first_d      = first_q;

      diff       = $signed({bus.din[11], bus.din}) - $signed({pred_q[11], pred_q});
      mag        = diff[12] ? 12'(-diff) : diff[11:0];
      st_sel     = step_of(idx_q);
      st_full    = {1'b0, st_q};
      st_half    = {2'b00, st_q[10:1]};
      st_quarter = {3'b000, st_q[10:2]};
      code_new   = {sign_q, cb_q};

      // 14 bits hold pred +/- 2910 without wrapping before saturation.
      pred_sum = sign_q ? $signed({{2{pred_q[11]}}, pred_q}) - $signed({2'b00, vp_q})
                        : $signed({{2{pred_q[11]}}, pred_q}) + $signed({2'b00, vp_q});
      adj      = cb_q[2] ? $signed({5'd0, cb_q[1:0], 1'b0}) + 8'sd2 : -8'sd1;
      idx_sum  = $signed({2'b00, idx_q}) + adj;

      if (cen) begin
         case (state_q)
            S_IDLE: begin
               if (bus.flush && phase_q) begin
                  dout_d       = pack(first_q, 4'h0);
                  dout_valid_d = 1'b1;
                  phase_d      = 1'b0;
               end else if (bus.din_valid) begin
                  sign_d  = diff[12];
                  d_d     = mag;
                  st_d    = st_sel;
                  vp_d    = {4'd0, st_sel[10:3]};
                  cb_d    = 3'd0;
                  state_d = S_B2;
               end
            end
            S_B2: begin
               if (d_q >= st_full) begin
                  cb_d[2] = 1'b1;
                  d_d     = d_q - st_full;
                  vp_d    = vp_q + st_full;
               end
               state_d = S_B1;
            end
            S_B1: begin
               if (d_q >= st_half) begin
                  cb_d[1] = 1'b1;
                  d_d     = d_q - st_half;
                  vp_d    = vp_q + st_half;
               end
               state_d = S_B0;
            end
            S_B0: begin
               if (d_q >= st_quarter) begin
                  cb_d[0] = 1'b1;
                  vp_d    = vp_q + st_quarter;
               end
               state_d = S_UPD;
            end
            S_UPD: begin
               if (pred_sum > 14'sd2047)       pred_d = 12'h7ff;
               else if (pred_sum < -14'sd2048) pred_d = 12'h800;
               else                            pred_d = pred_sum[11:0];
               if (idx_sum < 8'sd0)        idx_d = 6'd0;
               else if (idx_sum > 8'sd48)  idx_d = 6'd48;
               else                        idx_d = idx_sum[5:0];
               code_d       = code_new;
               code_valid_d = 1'b1;
               if (phase_q) begin
                  dout_d       = pack(first_q, code_new);
                  dout_valid_d = 1'b1;
               end else begin
                  first_d = code_new;
               end
               phase_d = ~phase_q;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Soft reset wins over any in-flight work, with or without cen.
      if (restart) begin
         state_d      = S_IDLE;
         pred_d       = 12'd0;
         idx_d        = IDX0;
         phase_d      = 1'b0;
         first_d      = first_q;
         code_d       = code_q;
         code_valid_d = 1'b0;
         dout_d       = dout_q;
         dout_valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sign_q       <= 1'b0;
         d_q          <= 12'd0;
         st_q         <= 11'd0;
         vp_q         <= 12'd0;
         cb_q         <= 3'd0;
         pred_q       <= 12'd0;
         idx_q        <= IDX0;
         code_q       <= 4'd0;
         code_valid_q <= 1'b0;
         dout_q       <= 8'd0;
         dout_valid_q <= 1'b0;
         phase_q      <= 1'b0;
         first_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         sign_q       <= sign_d;
         d_q          <= d_d;
         st_q         <= st_d;
         vp_q         <= vp_d;
         cb_q         <= cb_d;
         pred_q       <= pred_d;
         idx_q        <= idx_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         phase_q      <= phase_d;
         first_q      <= first_d;
      end
   end

   assign bus.din_ready  = (state_q == S_IDLE);
   assign bus.code       = code_q;
   assign bus.code_valid = code_valid_q;
   assign bus.pred       = pred_q;
   assign bus.idx        = idx_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign state_dbg      = state_q;
endmodule

// File: tb/tb_jt5205_enc.sv
// Directed bench for jt5205_enc: reset state, latency, code/pred/idx
// sequences, saturation, index clamping, packing, flush and restart.
module tb_jt5205_enc;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b1;
   logic       restart = 1'b0;
   logic [2:0] state_dbg;

   jt5205_enc_if ifc ();

   jt5205_enc #(.PACK_HI_FIRST(1'b1), .INIT_IDX(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .restart   (restart),
      .bus       (ifc),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0]  c_code;
   logic [11:0] c_pred;
   logic [5:0]  c_idx;
   logic        c_dv;
   logic [7:0]  c_dout;
   logic        got;
   int          lat;

   int step_tab[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,
                        118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,
                        598,658,724,796,876,963,1060,1166,1282,1411,1552};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offers one sample, waits for acceptance, then captures the resulting code.
   task automatic send(input logic [11:0] s);
      int n;
      @(negedge clk);
      ifc.din = s;
      ifc.din_valid = 1'b1;
      n = 0;
      while (!ifc.din_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      ifc.din_valid = 1'b0;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (ifc.code_valid) begin
            got    = 1'b1;
            c_code = ifc.code;
            c_pred = ifc.pred;
            c_idx  = ifc.idx;
            c_dv   = ifc.dout_valid;
            c_dout = ifc.dout;
         end
      end
      check("code_valid_seen", got, 1);
   endtask

   task automatic expect_code(input string tag, input logic [3:0] code, input logic [11:0] pred,
                              input logic [5:0] idx, input logic dv);
      check({tag, "_code"}, c_code, code);
      check({tag, "_pred"}, c_pred, pred);
      check({tag, "_idx"}, c_idx, idx);
      check({tag, "_dv"}, c_dv, dv);
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_no_cv", ifc.code_valid, 0);
      check("restart_no_dv", ifc.dout_valid, 0);
      check("restart_pred", ifc.pred, 0);
      check("restart_idx", ifc.idx, 0);
   endtask

   task automatic pulse_flush(input logic exp_dv, input logic [7:0] exp_dout);
      @(negedge clk);
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      check("flush_dv", ifc.dout_valid, exp_dv);
      if (exp_dv) check("flush_dout", ifc.dout, exp_dout);
   endtask

   // Reference encoder step on plain integers.
   function automatic void model_step(input int s, inout int p, inout int ix, output int c);
      int diff, d, st, vp, sg, b;
      diff = s - p;
      sg   = (diff < 0) ? 1 : 0;
      d    = sg ? -diff : diff;
      st   = step_tab[ix];
      vp   = st / 8;
      b    = 0;
      if (d >= st)     begin b += 4; d -= st;     vp += st;     end
      if (d >= st / 2) begin b += 2; d -= st / 2; vp += st / 2; end
      if (d >= st / 4) begin b += 1;              vp += st / 4; end
      p = sg ? p - vp : p + vp;
      if (p > 2047)  p = 2047;
      if (p < -2048) p = -2048;
      ix = ix + ((b >= 4) ? 2 * (b - 3) : -1);
      if (ix < 0)  ix = 0;
      if (ix > 48) ix = 48;
      c = sg * 8 + b;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] alt_din [6];
      logic [3:0]  alt_code[6];
      logic [11:0] alt_pred[6];
      logic [5:0]  alt_idx [6];
      logic [3:0]  neg_code[8];
      logic [11:0] neg_pred[8];
      logic [5:0]  neg_idx [8];
      int          sine_tab[16];
      int          mp, mi, mc, prev_c, cv_cnt;
      logic        wrapped;

      alt_din  = '{12'h800, 12'h7ff, 12'h800, 12'h7ff, 12'h800, 12'h7ff};
      alt_code = '{4'hf, 4'h7, 4'hf, 4'h7, 4'hf, 4'h7};
      alt_pred = '{12'(-43), 12'd250, 12'(-381), 12'd976, 12'(-1934), 12'd976};
      alt_idx  = '{6'd24, 6'd32, 6'd40, 6'd48, 6'd48, 6'd48};
      neg_code = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hc, 4'h8, 4'h0};
      neg_pred = '{12'(-30), 12'(-93), 12'(-229), 12'(-522), 12'(-1153), 12'(-1967),
                   12'(-2048), 12'(-1949)};
      neg_idx  = '{6'd8, 6'd16, 6'd24, 6'd32, 6'd40, 6'd42, 6'd41, 6'd40};
      sine_tab = '{0, 400, 800, 1100, 1300, 1500, 1300, 1100, 800, 400, 0, -400, -800,
                   -1100, -1500, -800};

      ifc.din = 12'd0;
      ifc.din_valid = 1'b0;
      ifc.flush = 1'b0;

      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", ifc.din_ready, 1);
      check("rst_code", ifc.code, 0);
      check("rst_cv", ifc.code_valid, 0);
      check("rst_pred", ifc.pred, 0);
      check("rst_idx", ifc.idx, 0);
      check("rst_dout", ifc.dout, 0);
      check("rst_dv", ifc.dout_valid, 0);
      check("rst_state", state_dbg, 0);

      // cen low: sample is not taken
      cen = 1'b0;
      ifc.din = 12'd5;
      ifc.din_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("cen_hold_state", state_dbg, 0);
      check("cen_hold_ready", ifc.din_ready, 1);
      ifc.din_valid = 1'b0;
      cen = 1'b1;

      // Two zero samples: codes 0 then 8, byte 0x08
      send(12'd0);
      check("latency", lat, 4);
      expect_code("zero0", 4'h0, 12'd2, 6'd0, 1'b0);
      send(12'd0);
      expect_code("zero1", 4'h8, 12'd0, 6'd0, 1'b1);
      check("zero_dout", c_dout, 8'h08);

      // Full-scale positive steps, then alternation up to the index clamp
      send(12'h7ff);
      expect_code("pos0", 4'h7, 12'd30, 6'd8, 1'b0);
      send(12'h7ff);
      expect_code("pos1", 4'h7, 12'd93, 6'd16, 1'b1);
      check("pos_dout", c_dout, 8'h77);
      for (int i = 0; i < 6; i++) begin
         send(alt_din[i]);
         expect_code("alt", alt_code[i], alt_pred[i], alt_idx[i], 1'(i % 2));
         if (i % 2 == 1) check("alt_dout", c_dout, 8'hf7);
      end

      // Hold +2047: monotonic rise, saturation at 2047, idx decays afterwards
      pulse_restart();
      wrapped = 1'b0;
      for (int i = 0; i < 40; i++) begin
         send(12'h7ff);
         if (c_pred[11]) wrapped = 1'b1;
         if (i == 5) expect_code("hi_s6", 4'h4, 12'd1967, 6'd42, 1'b1);
         if (i == 6) expect_code("hi_s7", 4'h0, 12'h7ff, 6'd41, 1'b0);
      end
      check("hi_no_wrap", wrapped, 0);
      expect_code("hi_end", 4'h0, 12'h7ff, 6'd8, 1'b1);

      // Hold -2048: saturation at -2048
      pulse_restart();
      for (int i = 0; i < 8; i++) begin
         send(12'h800);
         expect_code("lo", neg_code[i], neg_pred[i], neg_idx[i], 1'(i % 2));
      end

      // Flush with a half byte, flush racing a sample, flush with nothing pending
      pulse_restart();
      send(12'h7ff);
      expect_code("fl0", 4'h7, 12'd30, 6'd8, 1'b0);
      pulse_flush(1'b1, 8'h70);
      send(12'd0);
      expect_code("fl1", 4'hb, 12'd1, 6'd7, 1'b0);
      @(negedge clk);
      ifc.din = 12'd1;
      ifc.din_valid = 1'b1;
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      ifc.din_valid = 1'b0;
      check("race_dv", ifc.dout_valid, 1);
      check("race_dout", ifc.dout, 8'hb0);
      check("race_ready", ifc.din_ready, 1);
      send(12'd1);
      expect_code("fl2", 4'h0, 12'd4, 6'd6, 1'b0);
      send(12'd4);
      expect_code("fl3", 4'h0, 12'd7, 6'd5, 1'b1);
      pulse_flush(1'b0, 8'h00);

      // Restart drops a half byte and aborts an in-flight sample
      pulse_restart();
      send(12'h7ff);
      expect_code("rs0", 4'h7, 12'd30, 6'd8, 1'b0);
      pulse_restart();
      send(12'd0);
      expect_code("rs1", 4'h0, 12'd2, 6'd0, 1'b0);
      send(12'h7ff);
      expect_code("rs2", 4'h7, 12'd32, 6'd8, 1'b1);
      check("rs2_dout", c_dout, 8'h07);
      @(negedge clk);
      ifc.din = 12'h7ff;
      ifc.din_valid = 1'b1;
      @(negedge clk);
      ifc.din_valid = 1'b0;
      check("abort_busy", ifc.din_ready, 0);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("abort_ready", ifc.din_ready, 1);
      check("abort_pred", ifc.pred, 0);
      check("abort_idx", ifc.idx, 0);
      cv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ifc.code_valid || ifc.dout_valid) cv_cnt++;
      end
      check("abort_silent", cv_cnt, 0);
      send(12'd0);
      expect_code("rs3", 4'h0, 12'd2, 6'd0, 1'b0);

      // Sine-like sweep against the reference model
      pulse_restart();
      mp = 0;
      mi = 0;
      prev_c = 0;
      for (int i = 0; i < 16; i++) begin
         send(12'(sine_tab[i]));
         model_step(sine_tab[i], mp, mi, mc);
         expect_code("sine", 4'(mc), 12'(mp), 6'(mi), 1'(i % 2));
         if (i % 2 == 1) check("sine_dout", c_dout, {4'(prev_c), 4'(mc)});
         prev_c = mc;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
